// File: rtl/cnu_minsum_serial.sv
// Serial min-sum check node unit: accumulates DEG variable-to-check messages,
// then emits DEG check-to-variable messages with optional offset correction.
`timescale 1ns/1ps
module cnu_minsum_serial #(
    parameter int W      = 8,
    parameter int DEG    = 6,
    parameter int IDXW   = 3,
    parameter int OFFSET = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_msg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_msg,
    output logic [IDXW-1:0] out_idx,
    output logic            cnu_over
);

    typedef enum logic {ACCUM, EMIT} state_t;

    localparam logic [W-2:0]    MAG_MAX = '1;
    localparam logic [W-2:0]    OFF     = (W-1)'(OFFSET);
    localparam logic [IDXW-1:0] LAST    = IDXW'(DEG - 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] in_cnt_q, in_cnt_d;
    logic [IDXW-1:0] out_cnt_q, out_cnt_d;
    logic [W-2:0]    min1_q, min1_d;
    logic [W-2:0]    min2_q, min2_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            tsign_q, tsign_d;
    logic [DEG-1:0]  sign_q, sign_d;
    logic            cnu_over_q, cnu_over_d;

    logic            in_fire;
    logic            out_fire;
    logic [W-1:0]    in_abs;
    logic [W-2:0]    in_mag;
    logic [W-2:0]    mag_sel;
    logic [W-2:0]    mag_o;
    logic            out_sign;

    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == EMIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_idx   = out_cnt_q;
    assign cnu_over  = cnu_over_q;

    // Only the most negative code has its top bit left after negation; clamp it.
    always_comb begin
        in_abs = in_msg[W-1] ? (~in_msg + W'(1)) : in_msg;
        in_mag = in_abs[W-1] ? MAG_MAX : in_abs[W-2:0];
    end

    always_comb begin
        mag_sel  = (out_cnt_q == idx_q) ? min2_q : min1_q;
        mag_o    = (mag_sel > OFF) ? (mag_sel - OFF) : '0;
        out_sign = tsign_q ^ sign_q[out_cnt_q];
        if (!out_valid) begin
            out_msg = '0;
        end else if (out_sign) begin
            out_msg = -{1'b0, mag_o};
        end else begin
            out_msg = {1'b0, mag_o};
        end
    end

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        min1_d     = min1_q;
        min2_d     = min2_q;
        idx_d      = idx_q;
        tsign_d    = tsign_q;
        sign_d     = sign_q;
        cnu_over_d = 1'b0;

        case (state_q)
            ACCUM: begin
                if (in_fire) begin
                    sign_d[in_cnt_q] = in_msg[W-1];
                    tsign_d          = tsign_q ^ in_msg[W-1];
                    // Strict compare keeps the earliest index on ties.
                    if (in_cnt_q == '0) begin
                        min1_d = in_mag;
                        min2_d = MAG_MAX;
                        idx_d  = '0;
                    end else if (in_mag < min1_q) begin
                        min2_d = min1_q;
                        min1_d = in_mag;
                        idx_d  = in_cnt_q;
                    end else if (in_mag <= min2_q) begin
                        min2_d = in_mag;
                    end
                    if (in_cnt_q == LAST) begin
                        in_cnt_d = '0;
                        state_d  = EMIT;
                    end else begin
                        in_cnt_d = in_cnt_q + IDXW'(1);
                    end
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (out_cnt_q == LAST) begin
                        out_cnt_d  = '0;
                        state_d    = ACCUM;
                        cnu_over_d = 1'b1;
                        min1_d     = '0;
                        min2_d     = '0;
                        idx_d      = '0;
                        tsign_d    = 1'b0;
                        sign_d     = '0;
                    end else begin
                        out_cnt_d = out_cnt_q + IDXW'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            min1_q     <= '0;
            min2_q     <= '0;
            idx_q      <= '0;
            tsign_q    <= 1'b0;
            sign_q     <= '0;
            cnu_over_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            min1_q     <= min1_d;
            min2_q     <= min2_d;
            idx_q      <= idx_d;
            tsign_q    <= tsign_d;
            sign_q     <= sign_d;
            cnu_over_q <= cnu_over_d;
        end
    end

endmodule
